// File: rtl/uart_wrapper.sv
// UART command/response wrapper: assembles two received bytes into a 16-bit
// command and serialises one response byte per trmt pulse, full duplex.
module uart_wrapper #(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        trmt,
  input  logic [7:0]  resp,
  output logic        tx_done
);

  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] BAUD_FULL = CW'(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_HALF = CW'(BAUD_DIV / 2);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic {RX_IDLE, RX_RECV}     rx_state_t;
  typedef enum logic {WAIT_HIGH, WAIT_LOW}  asm_state_t;
  typedef enum logic {TX_IDLE, TX_XMIT}     tx_state_t;

  rx_state_t  rx_state, rx_next;
  asm_state_t asm_state, asm_next;
  tx_state_t  tx_state, tx_next;

  logic          rx_ff1, rx_ff2, rx_prev;
  logic [CW-1:0] rx_cnt;
  logic [3:0]    rx_bits;
  logic [7:0]    rx_shift;
  logic [7:0]    high_byte;
  logic          start_det, rx_tick, rx_done;

  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bits;
  logic [9:0]    tx_shift;
  logic          tx_load, tx_tick, tx_end;

  assign start_det = (rx_state == RX_IDLE) && rx_prev && !rx_ff2;
  assign rx_tick   = (rx_state == RX_RECV) && (rx_cnt == CNT_ONE);
  // The stop-bit sample is the 10th; by then rx_shift holds exactly the 8 data bits.
  assign rx_done   = rx_tick && (rx_bits == 4'd9);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state  <= RX_IDLE;
      asm_state <= WAIT_HIGH;
      tx_state  <= TX_IDLE;
    end else begin
      rx_state  <= rx_next;
      asm_state <= asm_next;
      tx_state  <= tx_next;
    end
  end

  always_comb begin
    rx_next  = rx_state;
    asm_next = asm_state;
    tx_next  = tx_state;
    case (rx_state)
      RX_IDLE: if (start_det) rx_next = RX_RECV;
      RX_RECV: if (rx_done)   rx_next = RX_IDLE;
      default: rx_next = RX_IDLE;
    endcase
    case (asm_state)
      WAIT_HIGH: if (rx_done) asm_next = WAIT_LOW;
      WAIT_LOW:  if (rx_done) asm_next = WAIT_HIGH;
      default:   asm_next = WAIT_HIGH;
    endcase
    case (tx_state)
      TX_IDLE: if (trmt)   tx_next = TX_XMIT;
      TX_XMIT: if (tx_end) tx_next = TX_IDLE;
      default: tx_next = TX_IDLE;
    endcase
  end

  // Counter reloads on the sampling cycle, so samples land exactly BAUD_DIV apart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ff1   <= 1'b1;
      rx_ff2   <= 1'b1;
      rx_prev  <= 1'b1;
      rx_cnt   <= '0;
      rx_bits  <= '0;
      rx_shift <= '0;
    end else begin
      rx_ff1  <= RX;
      rx_ff2  <= rx_ff1;
      rx_prev <= rx_ff2;
      if (start_det) begin
        rx_cnt  <= BAUD_HALF;
        rx_bits <= '0;
      end else if (rx_state == RX_RECV) begin
        if (rx_tick) begin
          rx_cnt   <= BAUD_FULL;
          rx_bits  <= rx_bits + 4'd1;
          rx_shift <= {rx_ff2, rx_shift[7:1]};
        end else begin
          rx_cnt <= rx_cnt - CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      high_byte <= '0;
      cmd       <= '0;
      cmd_rdy   <= 1'b0;
    end else begin
      if (rx_done && asm_state == WAIT_HIGH)
        high_byte <= rx_shift;
      if (rx_done && asm_state == WAIT_LOW) begin
        cmd     <= {high_byte, rx_shift};
        cmd_rdy <= 1'b1;
      end else if (clr_cmd_rdy || (start_det && asm_state == WAIT_HIGH)) begin
        cmd_rdy <= 1'b0;
      end
    end
  end

  assign tx_load = (tx_state == TX_IDLE) && trmt;
  assign tx_tick = (tx_state == TX_XMIT) && (tx_cnt == BAUD_LAST);
  assign tx_end  = tx_tick && (tx_bits == 4'd9);
  assign TX      = tx_shift[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift <= '1;
      tx_cnt   <= '0;
      tx_bits  <= '0;
      tx_done  <= 1'b0;
    end else if (tx_load) begin
      tx_shift <= {1'b1, resp, 1'b0};
      tx_cnt   <= '0;
      tx_bits  <= '0;
      tx_done  <= 1'b0;
    end else if (tx_state == TX_XMIT) begin
      if (tx_tick) begin
        tx_shift <= {1'b1, tx_shift[9:1]};
        tx_cnt   <= '0;
        tx_bits  <= tx_bits + 4'd1;
        if (tx_end) tx_done <= 1'b1;
      end else begin
        tx_cnt <= tx_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_uart_wrapper.sv
// Self-checking bench for uart_wrapper: drives serial commands and response
// requests, and compares every cycle against a frame-level behavioural model.
module tb_uart_wrapper;

  localparam int B = 32;

  logic        clk = 1'b0;
  logic        rst_n, RX, TX, cmd_rdy, clr_cmd_rdy, trmt, tx_done;
  logic [15:0] cmd;
  logic [7:0]  resp;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: expected command/ready, a don't-care flag for transition windows,
  // and the expected TX frame with the cycle its start bit appears.
  logic [15:0] exp_cmd;
  logic        exp_rdy;
  bit          busy;
  logic [9:0]  tx_frame;
  int          tx_start_cycle;

  uart_wrapper #(.BAUD_DIV(B)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .trmt(trmt), .resp(resp), .tx_done(tx_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b);
    RX = 1'b0;
    tick(B);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      tick(B);
    end
    RX = 1'b1;
    tick(B);
  endtask

  // Sends a full command, updating the model: ready drops at the high byte's
  // start bit and rises with the new value around the low byte's stop bit.
  task automatic applyStimulus(input logic [15:0] c, input bit coincident_clr);
    logic [7:0] byte_v;
    bit seen;
    for (int k = 0; k < 2; k++) begin
      byte_v = (k == 0) ? c[15:8] : c[7:0];
      RX = 1'b0;
      if (k == 0) begin
        busy = 1'b1; tick(5); exp_rdy = 1'b0; busy = 1'b0; tick(B - 5);
      end else begin
        tick(B);
      end
      for (int i = 0; i < 8; i++) begin
        RX = byte_v[i];
        tick(B);
      end
      RX = 1'b1;
      if (k == 0) begin
        tick(B);
      end else if (!coincident_clr) begin
        busy = 1'b1; tick(B/2 + 6);
        exp_cmd = c; exp_rdy = 1'b1; busy = 1'b0;
        tick(B - B/2 - 6);
      end else begin
        busy = 1'b1; clr_cmd_rdy = 1'b1; seen = 1'b0;
        for (int w = 0; w < B && !seen; w++) begin
          tick(1);
          if (cmd === c) begin
            seen = 1'b1;
            clr_cmd_rdy = 1'b0;
          end
        end
        clr_cmd_rdy = 1'b0;
        checkOutput("coincident_completion_seen", 16'(seen), 16'd1);
        if (seen) checkOutput("coincident_set_wins", 16'(cmd_rdy), 16'd1);
        exp_cmd = c; exp_rdy = 1'b1; busy = 1'b0;
        tick(B/2);
      end
      tick($urandom_range(2, 5));
    end
  endtask

  task automatic pulse_clr();
    clr_cmd_rdy = 1'b1; busy = 1'b1;
    tick(1);
    clr_cmd_rdy = 1'b0; exp_rdy = 1'b0;
    tick(1);
    busy = 1'b0;
  endtask

  // Requests a response and decodes TX mid-bit as a remote receiver would;
  // optionally fires a second trmt with different data during the frame.
  task automatic send_resp(input logic [7:0] v, input bit second_trmt);
    logic [9:0] got;
    resp = v; trmt = 1'b1;
    tick(1);
    trmt = 1'b0;
    tx_frame = {1'b1, v, 1'b0};
    tx_start_cycle = cyc;
    tick(B/2);
    for (int i = 0; i < 10; i++) begin
      got[i] = TX;
      if (second_trmt && i == 3) begin
        trmt = 1'b1; resp = ~v;
        tick(1);
        trmt = 1'b0; resp = v;
        tick(B - 1);
      end else begin
        tick(B);
      end
    end
    checkOutput("remote_rx_byte", 16'(got[8:1]), 16'(v));
    checkOutput("remote_rx_framing", 16'({got[9], got[0]}), 16'b10);
  endtask

  // Per-cycle comparison of all outputs against the model.
  initial begin
    int idx;
    logic exp_tx, exp_done;
    forever begin
      @(negedge clk);
      if (!busy) begin
        checkOutput("cmd", cmd, exp_cmd);
        checkOutput("cmd_rdy", 16'(cmd_rdy), 16'(exp_rdy));
      end
      if (tx_start_cycle < 0) begin
        exp_tx = 1'b1; exp_done = 1'b0;
      end else begin
        idx = cyc - tx_start_cycle;
        if (idx < 10 * B) begin
          exp_tx = tx_frame[idx / B]; exp_done = 1'b0;
        end else begin
          exp_tx = 1'b1; exp_done = 1'b1;
        end
      end
      checkOutput("TX", 16'(TX), 16'(exp_tx));
      checkOutput("tx_done", 16'(tx_done), 16'(exp_done));
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] c;
    logic [7:0]  r;
    rst_n = 1'b0; RX = 1'b1; clr_cmd_rdy = 1'b0; trmt = 1'b0; resp = '0;
    exp_cmd = '0; exp_rdy = 1'b0; busy = 1'b0; tx_frame = '1; tx_start_cycle = -1;
    tick(2);
    checkOutput("reset_cmd", cmd, 16'h0000);
    checkOutput("reset_cmd_rdy", 16'(cmd_rdy), 16'd0);
    checkOutput("reset_TX", 16'(TX), 16'd1);
    checkOutput("reset_tx_done", 16'(tx_done), 16'd0);
    rst_n = 1'b1;
    tick(3);

    applyStimulus(16'h4022, 1'b0);
    checkOutput("cmd_4022", cmd, 16'h4022);
    checkOutput("rdy_4022", 16'(cmd_rdy), 16'd1);
    pulse_clr();
    checkOutput("rdy_after_clr", 16'(cmd_rdy), 16'd0);
    checkOutput("cmd_after_clr", cmd, 16'h4022);

    send_resp(8'hA5, 1'b0);
    checkOutput("tx_done_after_A5", 16'(tx_done), 16'd1);

    applyStimulus(16'h0000, 1'b0);
    applyStimulus(16'hFFFF, 1'b0);
    checkOutput("cmd_FFFF", cmd, 16'hFFFF);
    checkOutput("rdy_FFFF", 16'(cmd_rdy), 16'd1);

    busy = 1'b1;
    send_frame(8'h40);
    rst_n = 1'b0;
    exp_cmd = '0; exp_rdy = 1'b0; tx_start_cycle = -1;
    #1;
    checkOutput("async_reset_cmd", cmd, 16'h0000);
    checkOutput("async_reset_rdy", 16'(cmd_rdy), 16'd0);
    busy = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(3);
    applyStimulus(16'h2213, 1'b0);
    checkOutput("cmd_2213", cmd, 16'h2213);

    fork
      applyStimulus(16'h5AC3, 1'b0);
      send_resp(8'hA5, 1'b1);
    join
    checkOutput("cmd_5AC3", cmd, 16'h5AC3);

    applyStimulus(16'h1234, 1'b1);
    checkOutput("cmd_1234", cmd, 16'h1234);
    pulse_clr();

    for (int n = 0; n < 6; n++) begin
      c = 16'($urandom);
      r = 8'($urandom);
      fork
        applyStimulus(c, 1'b0);
        begin
          if (n % 2 == 0) send_resp(r, 1'b0);
        end
      join
      if ($urandom_range(0, 1) == 1) pulse_clr();
      tick($urandom_range(1, 10));
    end

    tick(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
